// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the multi-channel ultrasonic range controller.
//   state_e    : controller state encoding
//   US_PER_CM  : echo round-trip time per centimetre, in microseconds
//   ch_width() : width of a channel index, never less than one bit
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_e;

    localparam int US_PER_CM = 58;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_median3.sv
// ranger_median3: per-channel 3-deep history of raw results plus a median
// compare stage. Used only when RANGER_MEDIAN_EN is defined.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   wr_valid    raw result written this cycle (combinational from the FSM)
//   wr_ch       channel of the raw result
//   wr_val      raw distance in cm (MAX_CM for a timeout)
//   dist_cm     median of the last three raw results, per channel
//   dist_valid  one-cycle pulse, one cycle after the history was updated
//   dist_ch     channel flagged by dist_valid
module ranger_median3 #(
    parameter int NUM_CH = 2,
    parameter int DIST_W = 16,
    parameter int CH_W   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [DIST_W-1:0]        wr_val,
    output logic [NUM_CH*DIST_W-1:0] dist_cm,
    output logic                     dist_valid,
    output logic [CH_W-1:0]          dist_ch
);

    logic [DIST_W-1:0]        hist_q [NUM_CH][3];
    logic [DIST_W-1:0]        hist_d [NUM_CH][3];
    logic                     pend_valid_q;
    logic [CH_W-1:0]          pend_ch_q;
    logic [NUM_CH*DIST_W-1:0] dist_q, dist_d;
    logic                     dist_valid_q;
    logic [CH_W-1:0]          dist_ch_q;

    function automatic logic [DIST_W-1:0] median3(input logic [DIST_W-1:0] a,
                                                  input logic [DIST_W-1:0] b,
                                                  input logic [DIST_W-1:0] c);
        logic [DIST_W-1:0] lo, hi, mid;
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        mid = (hi < c) ? hi : c;
        return (lo > mid) ? lo : mid;
    endfunction

    always_comb begin
        hist_d = hist_q;
        dist_d = dist_q;
        for (int k = 0; k < NUM_CH; k++) begin
            // Stage 1: shift the new raw result into the channel history.
            if (wr_valid && wr_ch == CH_W'(k)) begin
                hist_d[k][2] = hist_q[k][1];
                hist_d[k][1] = hist_q[k][0];
                hist_d[k][0] = wr_val;
            end
            // Stage 2: publish the median of the freshly updated history.
            if (pend_valid_q && pend_ch_q == CH_W'(k)) begin
                dist_d[k*DIST_W +: DIST_W] = median3(hist_q[k][0], hist_q[k][1], hist_q[k][2]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the history is a few flops per channel that must read as 0
            // after reset, so it is cleared like any other register.
            for (int k = 0; k < NUM_CH; k++) begin
                for (int j = 0; j < 3; j++) begin
                    hist_q[k][j] <= '0;
                end
            end
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            dist_q       <= '0;
            dist_valid_q <= 1'b0;
            dist_ch_q    <= '0;
        end else begin
            hist_q       <= hist_d;
            pend_valid_q <= wr_valid;
            pend_ch_q    <= wr_ch;
            dist_q       <= dist_d;
            dist_valid_q <= pend_valid_q;
            dist_ch_q    <= pend_ch_q;
        end
    end

    assign dist_cm    = dist_q;
    assign dist_valid = dist_valid_q;
    assign dist_ch    = dist_ch_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: multi-channel HC-SR04-style trigger/echo controller.
// Fires the sensors round-robin, one per fixed-length slot, measures the
// echo width directly in cm and publishes a per-channel distance.
// Optional feature: define RANGER_MEDIAN_EN to report the median of each
// channel's last three raw results (dist_valid then lags by one cycle).
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   run         1 = keep measuring; 0 = stop once the current slot ends
//   echo        raw asynchronous echo inputs, one per channel
//   trig        trigger outputs, at most one high at a time
//   dist_cm     latest distance per channel, ch k at [k*DIST_W +: DIST_W]
//   dist_valid  one-cycle pulse when a channel result is written
//   dist_ch     channel of the write flagged by dist_valid
//   timeout     sticky per channel: last result of that channel timed out
//   busy        controller is not idle
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int  CLK_HZ  = 100_000_000,
    parameter int  NUM_CH  = 2,
    parameter int  DIST_W  = 16,
    parameter int  TRIG_US = 10,
    parameter int  SLOT_MS = 60,
    parameter int  MAX_CM  = 400,
    parameter int  WAIT_US = 30000,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [NUM_CH-1:0]        echo,
    output logic [NUM_CH-1:0]        trig,
    output logic [NUM_CH*DIST_W-1:0] dist_cm,
    output logic                     dist_valid,
    output logic [CH_W-1:0]          dist_ch,
    output logic [NUM_CH-1:0]        timeout,
    output logic                     busy
);

    localparam int CLK_MHZ  = CLK_HZ / 1_000_000;
    localparam int TPC      = CLK_MHZ * US_PER_CM;   // clock ticks per cm
    localparam int TRIG_CYC = TRIG_US * CLK_MHZ;
    localparam int WAIT_CYC = WAIT_US * CLK_MHZ;
    localparam int SLOT_CYC = SLOT_MS * 1000 * CLK_MHZ;
    localparam int CNT_MAX  = (WAIT_CYC > TRIG_CYC) ? WAIT_CYC : TRIG_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int SLOT_W   = $clog2(SLOT_CYC + 1);
    localparam int TICK_W   = $clog2(TPC + 1);

    if (CLK_MHZ < 1 || (CLK_HZ % 1_000_000) != 0) begin : g_bad_clk
        $error("CLK_HZ must be a non-zero multiple of 1 MHz");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
        $error("NUM_CH must be 1..8");
    end
    if (MAX_CM >= 2**DIST_W) begin : g_bad_max
        $error("MAX_CM must fit in DIST_W bits");
    end
    if (SLOT_CYC <= TRIG_CYC + WAIT_CYC + MAX_CM * TPC) begin : g_bad_slot
        $error("slot too short for trigger, echo wait and maximum range");
    end

    // Two-flop synchroniser; everything downstream uses echo_sync_q.
    logic [NUM_CH-1:0] echo_meta_q, echo_sync_q;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;      // trigger width / echo-rise wait
    logic [SLOT_W-1:0] slot_q, slot_d;    // cycles since the slot's trigger started
    logic [TICK_W-1:0] tick_q, tick_d;    // sub-centimetre tick counter
    logic [DIST_W-1:0] cm_q, cm_d;
    logic [NUM_CH-1:0] trig_q, trig_d;
    logic [NUM_CH-1:0] timeout_q, timeout_d;

    logic              echo_sel;
    logic              wr_valid;
    logic [DIST_W-1:0] wr_val;
    logic              wr_to;

    assign echo_sel = echo_sync_q[ch_q];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        tick_d    = tick_q;
        cm_d      = cm_q;
        wr_valid  = 1'b0;
        wr_val    = '0;
        wr_to     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_sel) begin
                    // The cycle that sees the rise is the first echo-high tick.
                    state_d = ST_MEASURE;
                    tick_d  = TICK_W'(1);
                    cm_d    = '0;
                end else if (cnt_q == CNT_W'(WAIT_CYC - 1)) begin
                    state_d  = ST_HOLDOFF;
                    wr_valid = 1'b1;
                    wr_val   = DIST_W'(MAX_CM);
                    wr_to    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!echo_sel) begin
                    state_d  = ST_HOLDOFF;
                    wr_valid = 1'b1;
                    wr_val   = cm_q;
                end else if (tick_q == TICK_W'(TPC - 1)) begin
                    tick_d = '0;
                    cm_d   = cm_q + 1'b1;
                    if (cm_q == DIST_W'(MAX_CM - 1)) begin
                        state_d  = ST_HOLDOFF;
                        wr_valid = 1'b1;
                        wr_val   = DIST_W'(MAX_CM);
                        wr_to    = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (slot_q == SLOT_W'(SLOT_CYC - 1)) begin
                    ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                    state_d = run ? ST_TRIG : ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The slot is timed from the first trigger cycle, which fixes the
        // trigger-to-trigger period at exactly SLOT_CYC.
        if (state_d == ST_IDLE || (state_d == ST_TRIG && state_q != ST_TRIG)) begin
            slot_d = '0;
        end else begin
            slot_d = slot_q + 1'b1;
        end

        // Registered trigger, decoded from the next state to avoid glitches.
        trig_d = '0;
        if (state_d == ST_TRIG) begin
            trig_d[ch_d] = 1'b1;
        end

        timeout_d = timeout_q;
        if (wr_valid) begin
            timeout_d[ch_q] = wr_to;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            slot_q      <= '0;
            tick_q      <= '0;
            cm_q        <= '0;
            trig_q      <= '0;
            timeout_q   <= '0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            tick_q      <= tick_d;
            cm_q        <= cm_d;
            trig_q      <= trig_d;
            timeout_q   <= timeout_d;
        end
    end

    assign trig    = trig_q;
    assign timeout = timeout_q;
    assign busy    = (state_q != ST_IDLE);

`ifdef RANGER_MEDIAN_EN
    ranger_median3 #(
        .NUM_CH (NUM_CH),
        .DIST_W (DIST_W),
        .CH_W   (CH_W)
    ) u_median (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ch      (ch_q),
        .wr_val     (wr_val),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .dist_ch    (dist_ch)
    );
`else
    logic [NUM_CH*DIST_W-1:0] dist_q, dist_d;
    logic                     dist_valid_q;
    logic [CH_W-1:0]          dist_ch_q;

    always_comb begin
        dist_d = dist_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_valid && ch_q == CH_W'(k)) begin
                dist_d[k*DIST_W +: DIST_W] = wr_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dist_q       <= '0;
            dist_valid_q <= 1'b0;
            dist_ch_q    <= '0;
        end else begin
            dist_q       <= dist_d;
            dist_valid_q <= wr_valid;
            dist_ch_q    <= ch_q;
        end
    end

    assign dist_cm    = dist_q;
    assign dist_valid = dist_valid_q;
    assign dist_ch    = dist_ch_q;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger.
// Timing is shortened so the run stays small: 1 MHz clock, 2 ms slots,
// 300 us echo wait and a 20 cm range (1160 echo cycles saturate).
module tb_ultrasonic_ranger;

    localparam int CLK_HZ   = 1_000_000;
    localparam int NUM_CH   = 2;
    localparam int DIST_W   = 16;
    localparam int TRIG_US  = 10;
    localparam int SLOT_MS  = 2;
    localparam int MAX_CM   = 20;
    localparam int WAIT_US  = 300;
    localparam int TPC      = 58;
    localparam int TRIG_CYC = 10;
    localparam int WAIT_CYC = 300;
    localparam int SLOT_CYC = 2000;
    localparam int NEVER    = -1;

    logic                     clk;
    logic                     reset;
    logic                     run;
    logic [NUM_CH-1:0]        echo;
    logic [NUM_CH-1:0]        trig;
    logic [NUM_CH*DIST_W-1:0] dist_cm;
    logic                     dist_valid;
    logic [0:0]               dist_ch;
    logic [NUM_CH-1:0]        timeout;
    logic                     busy;

    ultrasonic_ranger #(
        .CLK_HZ  (CLK_HZ),
        .NUM_CH  (NUM_CH),
        .DIST_W  (DIST_W),
        .TRIG_US (TRIG_US),
        .SLOT_MS (SLOT_MS),
        .MAX_CM  (MAX_CM),
        .WAIT_US (WAIT_US)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .echo       (echo),
        .trig       (trig),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .dist_ch    (dist_ch),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rst_at_edge = 1'b1;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int s;     // first trigger cycle of the slot
        int ch;
        int wr;    // cycle in which the raw result becomes visible
        int val;
        bit to;
    } slot_t;

    slot_t slots[$];
    int    m_dist[NUM_CH];
    bit [NUM_CH-1:0] m_to;
    int    m_hist[NUM_CH][3];

    // Echo driven high in cycles r..r+w-1 is seen by the controller two
    // cycles later; the controller only listens from s+TRIG_CYC onward.
    // A result is visible the cycle after the controller decides it.
    function automatic slot_t predict(input int s, input int ch, input int r, input int w);
        slot_t e;
        int rs, fall, n;
        e.s  = s;
        e.ch = ch;
        if (w < 0) begin
            e.wr  = s + TRIG_CYC + WAIT_CYC;
            e.val = MAX_CM;
            e.to  = 1'b1;
        end else begin
            rs   = (r + 2 > s + TRIG_CYC) ? r + 2 : s + TRIG_CYC;
            fall = r + w + 2;
            n    = fall - rs;
            if (n >= MAX_CM * TPC) begin
                e.wr  = rs + MAX_CM * TPC;
                e.val = MAX_CM;
                e.to  = 1'b1;
            end else begin
                e.wr  = fall + 1;
                e.val = n / TPC;
                e.to  = 1'b0;
            end
        end
        return e;
    endfunction

`ifdef RANGER_MEDIAN_EN
    function automatic int med3(input int a, input int b, input int c);
        int q[$];
        q = '{a, b, c};
        q.sort();
        return q[1];
    endfunction
`endif

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [NUM_CH-1:0]        exp_trig;
        logic                     exp_busy, exp_valid;
        logic [0:0]               exp_ch;
        logic [NUM_CH*DIST_W-1:0] exp_dist;
        if (rst_at_edge) begin
            slots.delete();
            m_to = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_dist[k] = 0;
                for (int j = 0; j < 3; j++) m_hist[k][j] = 0;
            end
        end
        if (cyc >= 1) begin
            exp_trig  = '0;
            exp_busy  = 1'b0;
            exp_valid = 1'b0;
            exp_ch    = '0;
            foreach (slots[i]) begin
                if (cyc >= slots[i].s && cyc < slots[i].s + TRIG_CYC) exp_trig[slots[i].ch] = 1'b1;
                if (cyc >= slots[i].s && cyc < slots[i].s + SLOT_CYC) exp_busy = 1'b1;
                if (cyc == slots[i].wr) begin
                    m_to[slots[i].ch]       = slots[i].to;
                    m_hist[slots[i].ch][2]  = m_hist[slots[i].ch][1];
                    m_hist[slots[i].ch][1]  = m_hist[slots[i].ch][0];
                    m_hist[slots[i].ch][0]  = slots[i].val;
`ifndef RANGER_MEDIAN_EN
                    m_dist[slots[i].ch] = slots[i].val;
                    exp_valid = 1'b1;
                    exp_ch    = 1'(slots[i].ch);
`endif
                end
`ifdef RANGER_MEDIAN_EN
                if (cyc == slots[i].wr + 1) begin
                    m_dist[slots[i].ch] = med3(m_hist[slots[i].ch][0], m_hist[slots[i].ch][1],
                                               m_hist[slots[i].ch][2]);
                    exp_valid = 1'b1;
                    exp_ch    = 1'(slots[i].ch);
                end
`endif
            end
            for (int k = 0; k < NUM_CH; k++) exp_dist[k*DIST_W +: DIST_W] = DIST_W'(m_dist[k]);
            check("trig", trig, exp_trig);
            check("busy", busy, exp_busy);
            check("dist_valid", dist_valid, exp_valid);
            if (exp_valid) check("dist_ch", dist_ch, exp_ch);
            check("dist_cm", dist_cm, exp_dist);
            check("timeout", timeout, m_to);
        end
    end

    // ---------------- stimulus ----------------
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin_at(input int n);
        goto(n);
        @(negedge clk);
    endtask

    // One slot: echo on `ch` driven high for w cycles starting roff cycles
    // after the slot's first trigger cycle (w = NEVER: no echo at all).
    task automatic run_slot(input int s, input int ch, input int roff, input int w,
                            input bit noise, input bit drop_run);
        goto(s);
        slots.push_back(predict(s, ch, s + roff, w));
        if (w != NEVER) begin
            goto(s + roff);
            echo[ch] = 1'b1;
            if (noise) echo[1-ch] = 1'b1;
            if (drop_run) begin
                goto(s + roff + 100);
                run = 1'b0;
            end
            goto(s + roff + w);
            echo = '0;
        end
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        echo  = '0;
        goto(3);
        reset = 1'b0;
        run   = 1'b1;

        run_slot(4, 0, 50, 580, 1'b0, 1'b0);             // 580 cycles -> 10 cm
        pin_at(2003);
        check("pin_to_after_slot0", timeout, 2'b00);
`ifndef RANGER_MEDIAN_EN
        check("pin_ch0_10cm", dist_cm[15:0], 16'd10);
`endif
        run_slot(2004, 1, 50, NEVER, 1'b0, 1'b0);        // no echo -> timeout
        pin_at(4003);
        check("pin_to_ch1_set", timeout, 2'b10);
`ifndef RANGER_MEDIAN_EN
        check("pin_ch1_max", dist_cm[31:16], 16'd20);
`endif
        run_slot(4004, 0, 50, 57, 1'b0, 1'b0);           // 57 cycles -> 0 cm
`ifndef RANGER_MEDIAN_EN
        pin_at(6003);
        check("pin_ch0_0cm", dist_cm[15:0], 16'd0);
`endif
        run_slot(6004, 1, 50, 1159, 1'b0, 1'b0);         // 1159 cycles -> 19 cm
        pin_at(8003);
        check("pin_to_ch1_clear", timeout, 2'b00);
`ifndef RANGER_MEDIAN_EN
        check("pin_ch1_19cm", dist_cm[31:16], 16'd19);
`endif
        run_slot(8004, 0, 50, 1300, 1'b1, 1'b0);         // held past range, ch1 noise
        pin_at(10003);
        check("pin_to_ch0_set", timeout, 2'b01);
`ifdef RANGER_MEDIAN_EN
        check("pin_med_ch0", dist_cm[15:0], 16'd10);     // history 20,0,10
`else
        check("pin_ch0_sat", dist_cm[15:0], 16'd20);
`endif
        run_slot(10004, 1, 3, 600, 1'b0, 1'b0);          // already high at trigger end
        pin_at(12003);
`ifdef RANGER_MEDIAN_EN
        check("pin_med_ch1", dist_cm[31:16], 16'd19);    // history 10,19,20
`else
        check("pin_ch1_early", dist_cm[31:16], 16'd10);
`endif
        run_slot(12004, 0, 50, 580, 1'b0, 1'b1);         // run dropped mid-measure
        pin_at(14100);
        check("pin_idle_busy", busy, 1'b0);
        check("pin_idle_trig", trig, 2'b00);
        goto(14104);
        run = 1'b1;
        run_slot(14105, 1, 50, 116, 1'b0, 1'b0);         // resumes on ch1: 2 cm
        pin_at(16104);
`ifndef RANGER_MEDIAN_EN
        check("pin_ch1_2cm", dist_cm[31:16], 16'd2);
`endif
        run_slot(16105, 0, 50, NEVER, 1'b0, 1'b0);
        goto(16109);                                     // reset during the trigger
        reset = 1'b1;
        run   = 1'b0;
        pin_at(16110);
        check("pin_rst_trig", trig, 2'b00);
        goto(16113);
        reset = 1'b0;
        pin_at(16150);
        check("pin_rst_dist", dist_cm, 32'd0);
        check("pin_rst_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
